refresh_scheduler: RTL and testbench

- Consumes the one-cycle refresh tick from the refresh interval counter.
- Counts owed refreshes, requests the command bus from the arbiter and, once granted, issues PRECHARGE-ALL (if needed) then REFRESH to the command/PHY stage.
- Enforces tRP and tRFC, and drains backlog back-to-back while holding the grant.

---
 rtl/refresh_scheduler_if.sv | 25 ++
 rtl/refresh_scheduler.sv | 150 +++++++++++++++
 tb/tb_refresh_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/refresh_scheduler_if.sv
// Command-bus handshake between the refresh scheduler, the command arbiter
// and the PHY-facing command stage.
interface refresh_scheduler_if;
  logic       ref_req;
  logic       ref_gnt;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;

  modport master (
    output ref_req,
    output cmd_valid,
    output cmd,
    input  ref_gnt,
    input  cmd_ready
  );

  modport slave (
    input  ref_req,
    input  cmd_valid,
    input  cmd,
    output ref_gnt,
    output cmd_ready
  );
endinterface

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: counts owed refreshes, wins the command bus, issues
// PREA (if banks are open) then REF, honouring tRP/tRFC and draining backlog.
module refresh_scheduler #(
  parameter int unsigned MAX_PENDING = 8,
  parameter int unsigned PEND_W      = 4,
  parameter int unsigned TRP         = 3,
  parameter int unsigned TRFC        = 53
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  refresh_flag,
  input  logic                  all_banks_idle,
  refresh_scheduler_if.master   bus,
  output logic [PEND_W-1:0]     pending,
  output logic                  urgent,
  output logic                  ref_busy,
  output logic                  overflow
);

  localparam int unsigned TMAX = (TRP > TRFC) ? TRP : TRFC;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [PEND_W-1:0] MAXP     = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] URG_LVL  = PEND_W'(MAX_PENDING - 1);
  localparam logic [1:0]        CMD_NOP  = 2'b00;
  localparam logic [1:0]        CMD_PREA = 2'b01;
  localparam logic [1:0]        CMD_REF  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PREA_CMD,
    WAIT_RP,
    REF_CMD,
    WAIT_RFC
  } state_e;

  state_e            state_q;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [TW-1:0]     timer_q;
  logic              ref_req_q;
  logic              cmd_valid_q;
  logic [1:0]        cmd_q;
  logic              overflow_q;
  logic              ref_hs;

  assign ref_hs = (state_q == REF_CMD) && cmd_valid_q && bus.cmd_ready;

  // Tick and REF handshake together cancel, even at saturation.
  always_comb begin
    pending_d = pending_q;
    if (refresh_flag && !ref_hs) begin
      if (pending_q != MAXP) pending_d = pending_q + PEND_W'(1);
    end else if (!refresh_flag && ref_hs) begin
      pending_d = pending_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      timer_q     <= '0;
      ref_req_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      overflow_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (refresh_flag && (pending_q == MAXP)) overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (pending_q != '0) begin
            state_q   <= REQ;
            ref_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.ref_gnt) begin
            cmd_valid_q <= 1'b1;
            if (all_banks_idle) begin
              state_q <= REF_CMD;
              cmd_q   <= CMD_REF;
            end else begin
              state_q <= PREA_CMD;
              cmd_q   <= CMD_PREA;
            end
          end
        end
        PREA_CMD: begin
          if (bus.cmd_ready) begin
            state_q     <= WAIT_RP;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            timer_q     <= TW'(TRP - 1);
          end
        end
        // Timer is loaded with delay-1 so the next command lands exactly
        // at handshake cycle + delay.
        WAIT_RP: begin
          if (timer_q == TW'(1)) begin
            state_q     <= REF_CMD;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_REF;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        REF_CMD: begin
          if (bus.cmd_ready) begin
            state_q     <= WAIT_RFC;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            timer_q     <= TW'(TRFC - 1);
          end
        end
        WAIT_RFC: begin
          if (timer_q == TW'(1)) begin
            if (pending_q != '0) begin
              state_q     <= REF_CMD;
              cmd_valid_q <= 1'b1;
              cmd_q       <= CMD_REF;
            end else begin
              state_q   <= IDLE;
              ref_req_q <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          ref_req_q   <= 1'b0;
          cmd_valid_q <= 1'b0;
          cmd_q       <= CMD_NOP;
        end
      endcase
    end
  end

  assign bus.ref_req   = ref_req_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign pending       = pending_q;
  assign urgent        = (pending_q >= URG_LVL);
  assign ref_busy      = (state_q != IDLE);
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler: hand-timed scenarios with fixed
// expected values for latency, spacing, saturation and reset behaviour.
module tb_refresh_scheduler;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       refresh_flag = 1'b0;
  logic       all_banks_idle = 1'b1;
  logic [3:0] pending;
  logic       urgent, ref_busy, overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned cyc_cnt  = 0;
  int unsigned prea_cnt = 0;
  int unsigned ref_cnt  = 0;
  int unsigned hs_time [0:63];

  refresh_scheduler_if bus_if ();

  refresh_scheduler #(
    .MAX_PENDING (8),
    .PEND_W      (4),
    .TRP         (3),
    .TRFC        (53)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .refresh_flag   (refresh_flag),
    .all_banks_idle (all_banks_idle),
    .bus            (bus_if),
    .pending        (pending),
    .urgent         (urgent),
    .ref_busy       (ref_busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Handshakes are observed mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (bus_if.cmd_valid && bus_if.cmd_ready) begin
      if (bus_if.cmd == 2'b01) prea_cnt = prea_cnt + 1;
      if (bus_if.cmd == 2'b10) begin
        if (ref_cnt < 64) hs_time[ref_cnt] = cyc_cnt;
        ref_cnt = ref_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int unsigned max_cyc, input string tag);
    int unsigned n = 0;
    while (ref_busy && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 32'(ref_busy), 0);
  endtask

  initial begin
    int unsigned pb, rb;
    logic stable;
    bus_if.ref_gnt   = 1'b0;
    bus_if.cmd_ready = 1'b1;

    // Reset state
    #1 rst_b = 1'b0;
    step(); step();
    check("rst_pending",  32'(pending), 0);
    check("rst_ref_req",  32'(bus_if.ref_req), 0);
    check("rst_cmd_valid",32'(bus_if.cmd_valid), 0);
    check("rst_cmd",      32'(bus_if.cmd), 0);
    check("rst_urgent",   32'(urgent), 0);
    check("rst_busy",     32'(ref_busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_b = 1'b1;
    step();

    // 1: single tick, banks idle
    pb = prea_cnt; rb = ref_cnt;
    refresh_flag = 1'b1; step(); refresh_flag = 1'b0;
    check("t1_pend1", 32'(pending), 1);
    check("t1_req0",  32'(bus_if.ref_req), 0);
    step();
    check("t1_req1",  32'(bus_if.ref_req), 1);
    check("t1_busy1", 32'(ref_busy), 1);
    bus_if.ref_gnt = 1'b1; step(); bus_if.ref_gnt = 1'b0;
    check("t1_valid", 32'(bus_if.cmd_valid), 1);
    check("t1_cmd",   32'(bus_if.cmd), 2);
    step();
    check("t1_pend0", 32'(pending), 0);
    check("t1_valid0",32'(bus_if.cmd_valid), 0);
    repeat (51) step();
    check("t1_req_T52", 32'(bus_if.ref_req), 1);
    step();
    check("t1_req_T53", 32'(bus_if.ref_req), 0);
    check("t1_busy0",   32'(ref_busy), 0);
    check("t1_noprea",  prea_cnt - pb, 0);
    check("t1_nref",    ref_cnt - rb, 1);

    // 2: single tick, banks open -> PREA then REF at T+3
    pb = prea_cnt; rb = ref_cnt;
    all_banks_idle = 1'b0;
    refresh_flag = 1'b1; step(); refresh_flag = 1'b0;
    step();
    bus_if.ref_gnt = 1'b1; step(); bus_if.ref_gnt = 1'b0;
    check("t2_prea_valid", 32'(bus_if.cmd_valid), 1);
    check("t2_prea_cmd",   32'(bus_if.cmd), 1);
    step();
    check("t2_rp_T1", 32'(bus_if.cmd_valid), 0);
    step();
    check("t2_rp_T2", 32'(bus_if.cmd_valid), 0);
    step();
    check("t2_ref_T3_valid", 32'(bus_if.cmd_valid), 1);
    check("t2_ref_T3_cmd",   32'(bus_if.cmd), 2);
    step();
    repeat (52) step();
    check("t2_idle",  32'(ref_busy), 0);
    check("t2_req0",  32'(bus_if.ref_req), 0);
    check("t2_nprea", prea_cnt - pb, 1);
    check("t2_nref",  ref_cnt - rb, 1);

    // 3: PREA stalled by cmd_ready=0 for 5 cycles
    bus_if.cmd_ready = 1'b0;
    refresh_flag = 1'b1; step(); refresh_flag = 1'b0;
    step();
    bus_if.ref_gnt = 1'b1; step(); bus_if.ref_gnt = 1'b0;
    stable = (bus_if.cmd_valid === 1'b1) && (bus_if.cmd === 2'b01);
    repeat (4) begin
      step();
      stable = stable && (bus_if.cmd_valid === 1'b1) && (bus_if.cmd === 2'b01);
    end
    check("t3_prea_stable", 32'(stable), 1);
    bus_if.cmd_ready = 1'b1;
    step();
    check("t3_rp_T1", 32'(bus_if.cmd_valid), 0);
    step();
    check("t3_rp_T2", 32'(bus_if.cmd_valid), 0);
    step();
    check("t3_ref_T3", 32'(bus_if.cmd), 2);
    step();
    repeat (52) step();
    check("t3_idle", 32'(ref_busy), 0);
    all_banks_idle = 1'b1;

    // 4: three ticks held off, then drained back-to-back
    rb = ref_cnt;
    refresh_flag = 1'b1; repeat (3) step(); refresh_flag = 1'b0;
    check("t4_pend3",   32'(pending), 3);
    check("t4_urgent0", 32'(urgent), 0);
    repeat (3) step();
    check("t4_req_hold", 32'(bus_if.ref_req), 1);
    bus_if.ref_gnt = 1'b1; step(); bus_if.ref_gnt = 1'b0;
    wait_idle(300, "t4_timeout");
    check("t4_nref",  ref_cnt - rb, 3);
    check("t4_gap1",  hs_time[rb+1] - hs_time[rb], 53);
    check("t4_gap2",  hs_time[rb+2] - hs_time[rb+1], 53);
    check("t4_pend0", 32'(pending), 0);

    // 5: nine ticks -> saturation and sticky overflow
    rb = ref_cnt;
    refresh_flag = 1'b1;
    repeat (6) step();
    check("t5_pend6",   32'(pending), 6);
    check("t5_urg6",    32'(urgent), 0);
    step();
    check("t5_pend7",   32'(pending), 7);
    check("t5_urg7",    32'(urgent), 1);
    step();
    check("t5_pend8",   32'(pending), 8);
    check("t5_ovf8",    32'(overflow), 0);
    step();
    refresh_flag = 1'b0;
    check("t5_pend_sat", 32'(pending), 8);
    check("t5_ovf9",     32'(overflow), 1);
    bus_if.ref_gnt = 1'b1; step(); bus_if.ref_gnt = 1'b0;
    wait_idle(600, "t5_timeout");
    check("t5_nref",      ref_cnt - rb, 8);
    check("t5_pend0",     32'(pending), 0);
    check("t5_ovf_stick", 32'(overflow), 1);

    // 6: tick coincident with REF handshake, then reset in WAIT_RFC
    bus_if.cmd_ready = 1'b0;
    refresh_flag = 1'b1; step(); step(); refresh_flag = 1'b0;
    check("t6_pend2", 32'(pending), 2);
    bus_if.ref_gnt = 1'b1; step(); bus_if.ref_gnt = 1'b0;
    check("t6_valid", 32'(bus_if.cmd_valid), 1);
    bus_if.cmd_ready = 1'b1; refresh_flag = 1'b1;
    step();
    refresh_flag = 1'b0;
    check("t6_pend_coinc", 32'(pending), 2);
    repeat (5) step();
    check("t6_busy_wait", 32'(ref_busy), 1);
    #2 rst_b = 1'b0;
    #1;
    check("t6_rst_pend",  32'(pending), 0);
    check("t6_rst_req",   32'(bus_if.ref_req), 0);
    check("t6_rst_valid", 32'(bus_if.cmd_valid), 0);
    check("t6_rst_cmd",   32'(bus_if.cmd), 0);
    check("t6_rst_busy",  32'(ref_busy), 0);
    check("t6_rst_urg",   32'(urgent), 0);
    check("t6_rst_ovf",   32'(overflow), 0);
    step();
    rst_b = 1'b1;
    repeat (3) step();
    check("t6_post_req", 32'(bus_if.ref_req), 0);
    check("t6_post_pend", 32'(pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

endmodule
